iotdf_param: RTL and testbench

IOTDF_PARAM -- requirements
Module: iotdf_param

---
 rtl/iotdf_pkg.sv | 27 ++
 rtl/iotdf_topk.sv | 68 ++++++
 rtl/iotdf_param.sv | 222 ++++++++++++++++++++++
 tb/tb_iotdf_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/iotdf_pkg.sv
// Shared encodings for the IoT data filter: function-select codes and FSM states.
// Top-level optional feature: IOTDF_AVG_EN (enables the averaging function).
package iotdf_pkg;

    localparam logic [3:0] FN_MAX   = 4'd1;
    localparam logic [3:0] FN_MIN   = 4'd2;
    localparam logic [3:0] FN_TOPK  = 4'd3;
    localparam logic [3:0] FN_BOTK  = 4'd4;
    localparam logic [3:0] FN_AVG   = 4'd5;
    localparam logic [3:0] FN_EXT   = 4'd6;
    localparam logic [3:0] FN_EXC   = 4'd7;
    localparam logic [3:0] FN_PKMAX = 4'd8;
    localparam logic [3:0] FN_PKMIN = 4'd9;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_EVAL = 2'd2;
    localparam state_t ST_OUT  = 2'd3;

    // Functions whose ranking keeps the largest values at slot 0.
    function automatic logic fn_is_max(input logic [3:0] fn);
        return (fn == FN_MAX) || (fn == FN_TOPK) || (fn == FN_PKMAX);
    endfunction

endpackage

// File: rtl/iotdf_topk.sv
// Sorted K-entry ranking buffer; slot 0 holds the best value (largest in max
// mode, smallest in min mode). Equal values queue behind existing ones.
module iotdf_topk
    import iotdf_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int TOPK   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         ins,
    input  logic                         max_mode,
    input  logic [DATA_W-1:0]            din,
    output logic [TOPK-1:0][DATA_W-1:0]  ent,
    output logic [TOPK-1:0]              ent_vld
);

    logic [TOPK-1:0][DATA_W-1:0] ent_q, ent_d, prev_ent;
    logic [TOPK-1:0]             vld_q, vld_d, prev_vld, hit, prev_hit;

    genvar i;
    generate
        for (i = 0; i < TOPK; i++) begin : g_slot
            assign hit[i] = !vld_q[i] ||
                            (max_mode ? (din > ent_q[i]) : (din < ent_q[i]));
        end
    endgenerate

    // Neighbour views: slot i sees slot i-1 (slot 0 sees nothing).
    assign prev_ent = ent_q << DATA_W;
    assign prev_vld = vld_q << 1;
    assign prev_hit = hit << 1;

    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        if (clr) begin
            vld_d = '0;
        end else if (ins) begin
            for (int k = 0; k < TOPK; k++) begin
                if (hit[k]) begin
                    if (!prev_hit[k]) begin
                        ent_d[k] = din;
                        vld_d[k] = 1'b1;
                    end else begin
                        ent_d[k] = prev_ent[k];
                        vld_d[k] = prev_vld[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_q <= '0;
            vld_q <= '0;
        end else begin
            ent_q <= ent_d;
            vld_q <= vld_d;
        end
    end

    assign ent     = ent_q;
    assign ent_vld = vld_q;

endmodule

// File: rtl/iotdf_param.sv
// IoT data filter: assembles packets from beats, evaluates a round of packets
// with the selected function. Define IOTDF_AVG_EN to build the averaging path.
module iotdf_param
    import iotdf_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int IN_W        = 8,
    parameter int PKT_PER_RND = 8,
    parameter int TOPK        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [IN_W-1:0]   iot_in,
    input  logic [3:0]        fn_sel,
    input  logic [DATA_W-1:0] lo_th,
    input  logic [DATA_W-1:0] hi_th,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] iot_out,
    output logic              rnd_done
);

    localparam int BEATS = DATA_W / IN_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PCW   = $clog2(PKT_PER_RND);
    localparam int OIW   = (TOPK > 1) ? $clog2(TOPK) : 1;

    state_t            state_q, state_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [PCW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [OIW-1:0]    out_idx_q, out_idx_d;
    logic [3:0]        fn_q, fn_d;
    logic [DATA_W-1:0] pkt_q, pkt_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic              peak_vld_q, peak_vld_d;
    logic              valid_q, valid_d;
    logic              rnd_done_q, rnd_done_d;
    logic [DATA_W-1:0] iot_out_q, iot_out_d;

    logic accept, rnd_start, beat_last, pkt_last, out_last, sel_hit;
    logic [TOPK-1:0][DATA_W-1:0] ent;
    logic [TOPK-1:0]             ent_vld;

    assign busy      = (state_q == ST_EVAL) || (state_q == ST_OUT);
    assign accept    = in_en && !busy;
    assign rnd_start = accept && (state_q == ST_IDLE);
    assign beat_last = (beat_cnt_q == BCW'(BEATS - 1));
    assign pkt_last  = (pkt_cnt_q == PCW'(PKT_PER_RND - 1));
    assign out_last  = ((fn_q == FN_TOPK) || (fn_q == FN_BOTK)) ?
                       (out_idx_q == OIW'(TOPK - 1)) : 1'b1;

    always_comb begin
        sel_hit = 1'b0;
        if (fn_q == FN_EXT)
            sel_hit = (lo_th < pkt_q) && (pkt_q < hi_th);
        else if (fn_q == FN_EXC)
            sel_hit = (pkt_q < lo_th) || (pkt_q > hi_th);
    end

    iotdf_topk #(
        .DATA_W (DATA_W),
        .TOPK   (TOPK)
    ) u_topk (
        .clk      (clk),
        .rst      (rst),
        .clr      (rnd_start),
        .ins      (state_q == ST_EVAL),
        .max_mode (fn_is_max(fn_q)),
        .din      (pkt_q),
        .ent      (ent),
        .ent_vld  (ent_vld)
    );

`ifdef IOTDF_AVG_EN
    localparam int ACC_W = DATA_W + PCW;

    // Wide enough that a full round of all-ones packets cannot overflow.
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] avg;

    always_comb begin
        acc_d = acc_q;
        if (rnd_start)
            acc_d = '0;
        else if (state_q == ST_EVAL)
            acc_d = acc_q + ACC_W'(pkt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

    assign avg = acc_q[ACC_W-1:PCW];
`endif

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        out_idx_d  = out_idx_q;
        fn_d       = fn_q;
        pkt_d      = pkt_q;
        peak_d     = peak_q;
        peak_vld_d = peak_vld_q;
        valid_d    = 1'b0;
        rnd_done_d = 1'b0;
        iot_out_d  = iot_out_q;

        // Beat assembly; accept is only possible in IDLE or LOAD.
        if (accept) begin
            pkt_d = (pkt_q << IN_W) | DATA_W'(iot_in);
            if (beat_last) begin
                beat_cnt_d = '0;
                state_d    = ST_EVAL;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                state_d    = ST_LOAD;
            end
        end

        if (rnd_start) begin
            fn_d      = fn_sel;
            pkt_cnt_d = '0;
            // A new function invalidates the stored peak.
            if (fn_sel != fn_q) peak_vld_d = 1'b0;
        end

        case (state_q)
            ST_EVAL: begin
                if (sel_hit) begin
                    valid_d   = 1'b1;
                    iot_out_d = pkt_q;
                end
                if (pkt_last) begin
                    pkt_cnt_d = '0;
                    state_d   = ST_OUT;
                end else begin
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_OUT: begin
                case (fn_q)
                    FN_MAX, FN_MIN: begin
                        valid_d   = 1'b1;
                        iot_out_d = ent[0];
                    end
                    FN_TOPK, FN_BOTK: begin
                        valid_d = ent_vld[out_idx_q];
                        if (ent_vld[out_idx_q]) iot_out_d = ent[out_idx_q];
                    end
`ifdef IOTDF_AVG_EN
                    FN_AVG: begin
                        valid_d   = 1'b1;
                        iot_out_d = avg;
                    end
`endif
                    FN_PKMAX: begin
                        if (!peak_vld_q || ent[0] >= peak_q) begin
                            valid_d    = 1'b1;
                            iot_out_d  = ent[0];
                            peak_d     = ent[0];
                            peak_vld_d = 1'b1;
                        end
                    end
                    FN_PKMIN: begin
                        if (!peak_vld_q || ent[0] <= peak_q) begin
                            valid_d    = 1'b1;
                            iot_out_d  = ent[0];
                            peak_d     = ent[0];
                            peak_vld_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
                rnd_done_d = out_last;
                if (out_last) begin
                    out_idx_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    out_idx_d = out_idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            out_idx_q  <= '0;
            fn_q       <= '0;
            pkt_q      <= '0;
            peak_q     <= '0;
            peak_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            rnd_done_q <= 1'b0;
            iot_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            out_idx_q  <= out_idx_d;
            fn_q       <= fn_d;
            pkt_q      <= pkt_d;
            peak_q     <= peak_d;
            peak_vld_q <= peak_vld_d;
            valid_q    <= valid_d;
            rnd_done_q <= rnd_done_d;
            iot_out_q  <= iot_out_d;
        end
    end

    assign valid    = valid_q;
    assign rnd_done = rnd_done_q;
    assign iot_out  = iot_out_q;

endmodule

// File: tb/tb_iotdf_param.sv
// Directed bench for iotdf_param at default parameters (16 beats/packet,
// 8 packets/round, TOPK=2); expected results are hand-computed per vector.
module tb_iotdf_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [3:0]   fn_sel;
    logic [127:0] lo_th, hi_th;
    logic         busy, valid, rnd_done;
    logic [127:0] iot_out;

    int checks = 0;
    int fails  = 0;
    int rnd_cnt = 0;
    int n0;
    logic [127:0] outq [$];
    logic         doneq [$];
    logic [127:0] pk [8];

    iotdf_param dut (
        .clk      (clk),
        .rst      (rst),
        .in_en    (in_en),
        .iot_in   (iot_in),
        .fn_sel   (fn_sel),
        .lo_th    (lo_th),
        .hi_th    (hi_th),
        .busy     (busy),
        .valid    (valid),
        .iot_out  (iot_out),
        .rnd_done (rnd_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            outq.push_back(iot_out);
            doneq.push_back(rnd_done);
        end
        if (rnd_done) rnd_cnt <= rnd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a negedge; holds the beat until the DUT is not busy.
    task automatic send_beat(input logic [7:0] b, input int gap);
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("busy_wait", busy, 0);
        in_en  = 1'b1;
        iot_in = b;
        @(negedge clk);
        in_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [127:0] v, input int nb, input int gap);
        for (int i = 0; i < nb; i++) send_beat(v[127-8*i -: 8], gap);
    endtask

    // fn_sel is scrambled after the first packet; the DUT must ignore it.
    task automatic send_round(input logic [3:0] fn, input int gap);
        fn_sel = fn;
        for (int p = 0; p < 8; p++) begin
            send_pkt(pk[p], 16, gap);
            fn_sel = ~fn;
        end
    endtask

    task automatic wait_rnd(input int base);
        int t = 0;
        while (rnd_cnt == base && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("rnd_done_seen", (t < 400), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_round(input logic [3:0] fn, input int gap);
        outq.delete();
        doneq.delete();
        n0 = rnd_cnt;
        send_round(fn, gap);
        wait_rnd(n0);
    endtask

    initial begin
        rst = 1'b0; in_en = 1'b0; iot_in = '0; fn_sel = '0; lo_th = '0; hi_th = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", rnd_done, 0);
        chk("rst_out", iot_out, 0);
        rst = 1'b1;
        @(negedge clk);

        // Max over 1..8
        pk = '{128'd1, 128'd2, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7, 128'd8};
        run_round(4'd1, 0);
        chk("f1_count", outq.size(), 1);
        chk("f1_value", outq[0], 128'd8);
        chk("f1_done_with_valid", doneq[0], 1);
        repeat (5) @(negedge clk);
        chk("f1_hold", iot_out, 128'd8);

        // Top-2 with a duplicate maximum
        pk = '{128'd5, 128'd9, 128'd9, 128'd1, 128'd0, 128'd3, 128'd2, 128'd7};
        run_round(4'd3, 0);
        chk("f3_count", outq.size(), 2);
        chk("f3_first", outq[0], 128'd9);
        chk("f3_second", outq[1], 128'd9);
        chk("f3_done_first", doneq[0], 0);
        chk("f3_done_last", doneq[1], 1);

        // Min with in_en toggling every other cycle
        pk = '{128'd30, 128'd12, 128'd40, 128'd7, 128'd99, 128'd15, 128'd8, 128'd20};
        run_round(4'd2, 1);
        chk("f2_stall_count", outq.size(), 1);
        chk("f2_stall_value", outq[0], 128'd7);

        // Reset in the middle of packet 3
        outq.delete();
        n0 = rnd_cnt;
        fn_sel = 4'd2;
        pk = '{128'd3, 128'd4, 128'd5, 128'd6, 128'd7, 128'd8, 128'd9, 128'd10};
        send_pkt(pk[0], 16, 1);
        send_pkt(pk[1], 16, 1);
        send_pkt(pk[2], 7, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_out", iot_out, 0);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_rst_no_valid", outq.size(), 0);
        chk("mid_rst_no_done", rnd_cnt - n0, 0);
        pk = '{128'd50, 128'd60, 128'd45, 128'd70, 128'd80, 128'd90, 128'd100, 128'd44};
        run_round(4'd2, 0);
        chk("post_rst_count", outq.size(), 1);
        chk("post_rst_min", outq[0], 128'd44);

        // Extract / exclude with strict bounds
        lo_th = 128'd10; hi_th = 128'd20;
        pk = '{128'd10, 128'd11, 128'd19, 128'd20, 128'd0, 128'd5, 128'd25, 128'd30};
        run_round(4'd6, 0);
        chk("f6_count", outq.size(), 2);
        chk("f6_first", outq[0], 128'd11);
        chk("f6_second", outq[1], 128'd19);
        run_round(4'd7, 0);
        chk("f7_count", outq.size(), 4);
        chk("f7_first", outq[0], 128'd0);
        chk("f7_last", outq[3], 128'd30);

        // Average (only when the averaging path is built)
        for (int p = 0; p < 8; p++) pk[p] = '1;
        run_round(4'd5, 0);
`ifdef IOTDF_AVG_EN
        chk("f5_ones_count", outq.size(), 1);
        chk("f5_ones_value", outq[0], {128{1'b1}});
`else
        chk("f5_off_count", outq.size(), 0);
`endif
        pk = '{128'd1, 128'd1, 128'd1, 128'd1, 128'd1, 128'd1, 128'd1, 128'd2};
        run_round(4'd5, 0);
`ifdef IOTDF_AVG_EN
        chk("f5_floor_value", outq[0], 128'd1);
`else
        chk("f5_off_count2", outq.size(), 0);
`endif

        // Peak-max over three rounds: 50, 40 (suppressed), 60
        outq.delete();
        n0 = rnd_cnt;
        fn_sel = 4'd8;
        pk = '{128'd10, 128'd50, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7, 128'd8};
        send_round(4'd8, 0);
        wait_rnd(n0);
        pk = '{128'd40, 128'd1, 128'd2, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7};
        send_round(4'd8, 0);
        wait_rnd(n0 + 1);
        pk = '{128'd1, 128'd2, 128'd60, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7};
        send_round(4'd8, 0);
        wait_rnd(n0 + 2);
        chk("f8_rounds", rnd_cnt - n0, 3);
        chk("f8_count", outq.size(), 2);
        chk("f8_first", outq[0], 128'd50);
        chk("f8_third", outq[1], 128'd60);

        // Undefined function: packets consumed, no output
        run_round(4'd0, 0);
        chk("undef_count", outq.size(), 0);
        chk("undef_hold", iot_out, 128'd60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
